ball_engine: RTL
================

Name: ball_engine

Overview:
Multi-ball successor to the single bouncing-ball demo. Animates NUM_BALLS square sprites that bounce off the visible-area edges, and renders them into the RGB332 pixel stream. Sits between vga_controller (hcount/vcount/vblank) and the board colour pins. Ball positions update once per frame, one ball per cycle, through a sequential update FSM started by the rising edge of vblank.

Parameters:
NUM_BALLS, 4, number of sprites (1..16)
HPIXELS, 640, visible width in pixels
VPIXELS, 480, visible height in pixels
BALL_SIZE, 8, sprite edge in pixels; a sprite covers x..x+BALL_SIZE-1
INIT_X, 310, reset x of ball 0
INIT_Y, 230, reset y of every ball
STAGGER, 24, reset x offset between consecutive balls; INIT_X+(NUM_BALLS-1)*STAGGER must be <= HPIXELS-BALL_SIZE
BALL_COLORS, {8'hE0,8'h1C,8'h03,8'hFF}, packed RGB332 per ball, ball 0 in the LSB byte
BG_COLOR, 8'h00, RGB332 background inside the visible area

Ports:
clk  in  1  pixel clock, same clock as vga_controller
rst  in  1  synchronous, active-high reset
hcount  in  11  current pixel column from vga_controller
vcount  in  11  current pixel row from vga_controller
vblank  in  1  vertical blank from vga_controller
speed  in  4  pixels per frame on both axes; sampled on the vblank rising edge
pause  in  1  1 = freeze all ball motion
red  out  3  registered red
green  out  3  registered green
blue  out  2  registered blue
busy  out  1  high while the update FSM is walking the balls
bounce  out  1  one-cycle pulse when the ball being processed reflects on any axis
bounce_cnt  out  8  total reflections, wraps at 255->0

Behaviour:
- Reset: ball i x = INIT_X + i*STAGGER, y = INIT_Y, h_dir = i[0], v_dir = i[1] (0 = RIGHT/DOWN, 1 = LEFT/UP). Outputs after reset: red/green/blue = 0, busy = 0, bounce = 0, bounce_cnt = 0. FSM state = IDLE, vblank_q = 0.
- Edge detect: frame_tick = vblank & ~vblank_q. vblank_q is registered every cycle.
- FSM IDLE: on frame_tick with pause = 0, latch speed into spd_r, set idx = 0, and go to UPDATE. If pause = 1, the tick is ignored.
- FSM UPDATE: busy = 1. Each cycle process ball idx; when idx == NUM_BALLS-1, go to IDLE. busy is high for exactly NUM_BALLS cycles, starting the cycle after the tick. A frame_tick during UPDATE is ignored.
- Per-axis step, using max = HPIXELS-BALL_SIZE (or VPIXELS-BALL_SIZE for y):
  - Dir 0: if pos+spd_r > max, then pos = max, dir = 1, reflect; else pos += spd_r.
  - Dir 1: if pos < spd_r, then pos = 0, dir = 0, reflect; else pos -= spd_r.
  - Arithmetic is in 12 bits, so there is no overflow.
  - spd_r = 0 produces no movement and no reflect.
- bounce = 1 in the cycle after a processed ball reflected on x, y, or both. A corner hit counts once. bounce_cnt increments on each bounce pulse.
- Pixel path:
  - hit_i = (x_i <= hcount < x_i+BALL_SIZE) && (y_i <= vcount < y_i+BALL_SIZE).
  - The lowest index hit wins overlaps.
  - Outside the visible area (hcount >= HPIXELS or vcount >= VPIXELS) the colour is 0. Otherwise it is the winning ball's colour, or BG_COLOR if no ball hits.
  - Latency is 1 clk from hcount/vcount to red/green/blue.
  - Rendering continues during pause and busy. Updates happen only in vblank, so there is no tearing.
- Reset mid-UPDATE: on the next edge all state returns to reset values; the partial update is discarded.

Decomposition:
- vga_defs.vh holds: HPIXELS/VPIXELS defaults, RIGHT/LEFT/DOWN/UP direction constants, RGB332 field widths, and the RGB332 split macro. It is shared with vga2 and vga_controller.
- One sub-module, ball_axis_step: combinational single-axis step.
  - Inputs: pos, dir, spd, max.
  - Outputs: next pos, next dir, reflect.
  - Instantiated twice (x, y) on the indexed ball.

Test Plan:
- Reset, NUM_BALLS=2, speed=4, one vblank rise -> busy high for 2 cycles; ball0 (310,230)->(314,234); ball1 (334,230)->(330,234); bounce stays 0.
- Ball0 forced to x=630 with dir RIGHT, speed=4 -> x=632, dir LEFT, one bounce pulse, bounce_cnt=1; next frame x=628.
- Ball0 at x=2 with dir LEFT, speed=4 -> x=0, dir RIGHT, bounce. With speed=0 -> position unchanged and no pulse.
- Pixel checks at reset positions, each one clk later:
  - (hcount,vcount)=(310,230) -> E0.
  - (318,230) -> BG.
  - Ball1 moved onto (310,230) -> still E0.
  - (700,100) -> 0.
- pause=1 across a vblank rise -> busy stays 0 and positions are unchanged. speed changed 3->7 mid-frame -> 7 is applied only at the next rise.
- rst asserted in the 2nd UPDATE cycle -> next cycle busy=0, bounce_cnt=0, all balls at reset positions and directions.

Source files
------------

// File: rtl/ball_engine_pkg.sv
// Shared definitions for the ball engine: position width, direction encoding,
// RGB332 field layout and the colour split helper.
package ball_engine_pkg;

  // 12-bit positions leave headroom so pos+speed never wraps.
  localparam int unsigned PosW       = 12;
  localparam int unsigned DefHPixels = 640;
  localparam int unsigned DefVPixels = 480;

  // Direction bit per axis: 0 = RIGHT/DOWN (increasing), 1 = LEFT/UP.
  localparam logic DirFwd = 1'b0;
  localparam logic DirRev = 1'b1;

  localparam int unsigned RedW   = 3;
  localparam int unsigned GreenW = 3;
  localparam int unsigned BlueW  = 2;

  typedef enum logic [0:0] {StIdle, StUpdate} state_e;

  typedef struct packed {
    logic [RedW-1:0]   r;
    logic [GreenW-1:0] g;
    logic [BlueW-1:0]  b;
  } rgb332_t;

  function automatic rgb332_t rgb332_split(input logic [7:0] c);
    rgb332_t s;
    s.r = c[7:5];
    s.g = c[4:2];
    s.b = c[1:0];
    return s;
  endfunction

endpackage

// File: rtl/ball_engine_if.sv
// Video-side bundle for the ball engine: timing inputs, controls, colour and status.
interface ball_engine_if;
  import ball_engine_pkg::*;

  logic [10:0]       hcount;
  logic [10:0]       vcount;
  logic              vblank;
  logic [3:0]        speed;
  logic              pause;
  logic [RedW-1:0]   red;
  logic [GreenW-1:0] green;
  logic [BlueW-1:0]  blue;
  logic              busy;
  logic              bounce;
  logic [7:0]        bounce_cnt;

  modport master (
    output hcount, vcount, vblank, speed, pause,
    input  red, green, blue, busy, bounce, bounce_cnt
  );

  modport slave (
    input  hcount, vcount, vblank, speed, pause,
    output red, green, blue, busy, bounce, bounce_cnt
  );

endinterface

// File: rtl/ball_axis_step.sv
// Combinational single-axis step: advance a position by spd, clamping and
// reflecting at 0 and max.
module ball_axis_step
  import ball_engine_pkg::*;
(
  input  logic [PosW-1:0] i_pos,
  input  logic            i_dir,
  input  logic [3:0]      i_spd,
  input  logic [PosW-1:0] i_max,
  output logic [PosW-1:0] o_pos,
  output logic            o_dir,
  output logic            o_reflect
);

  logic [PosW-1:0] w_spd;
  logic [PosW-1:0] w_sum;

  assign w_spd = {{(PosW-4){1'b0}}, i_spd};
  assign w_sum = i_pos + w_spd;

  // Step toward the wall in the current direction; clamp and flip on overshoot.
  always_comb begin
    o_pos     = i_pos;
    o_dir     = i_dir;
    o_reflect = 1'b0;
    if (i_dir == DirFwd) begin
      if (w_sum > i_max) begin
        o_pos     = i_max;
        o_dir     = DirRev;
        o_reflect = 1'b1;
      end else begin
        o_pos = w_sum;
      end
    end else begin
      if (i_pos < w_spd) begin
        o_pos     = '0;
        o_dir     = DirFwd;
        o_reflect = 1'b1;
      end else begin
        o_pos = i_pos - w_spd;
      end
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Multi-ball bouncing sprite engine. Positions update once per frame, one ball
// per cycle, starting on the vblank rising edge; sprites render into RGB332.
module ball_engine
  import ball_engine_pkg::*;
#(
  parameter int unsigned          NUM_BALLS   = 4,
  parameter int unsigned          HPIXELS     = DefHPixels,
  parameter int unsigned          VPIXELS     = DefVPixels,
  parameter int unsigned          BALL_SIZE   = 8,
  parameter int unsigned          INIT_X      = 310,
  parameter int unsigned          INIT_Y      = 230,
  parameter int unsigned          STAGGER     = 24,
  parameter logic [8*NUM_BALLS-1:0] BALL_COLORS = 32'hFF031CE0,
  parameter logic [7:0]           BG_COLOR    = 8'h00
) (
  input logic          i_clk,
  input logic          i_rst,
  ball_engine_if.slave bus
);

  localparam int unsigned    IdxW    = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BALLS - 1);
  localparam logic [PosW-1:0] XMax    = PosW'(HPIXELS - BALL_SIZE);
  localparam logic [PosW-1:0] YMax    = PosW'(VPIXELS - BALL_SIZE);
  localparam logic [PosW-1:0] Size    = PosW'(BALL_SIZE);

  state_e          r_state, w_state_next;
  logic            r_vblank_q;
  logic            w_frame_tick, w_start, w_proc;
  logic [3:0]      r_spd;
  logic [IdxW-1:0] r_idx;

  logic [PosW-1:0]      r_x [NUM_BALLS];
  logic [PosW-1:0]      r_y [NUM_BALLS];
  logic [NUM_BALLS-1:0] r_hdir, r_vdir;

  logic [PosW-1:0] w_x_cur, w_y_cur, w_x_next, w_y_next;
  logic            w_hdir_cur, w_vdir_cur, w_hdir_next, w_vdir_next;
  logic            w_x_refl, w_y_refl;

  logic            r_bounce;
  logic [7:0]      r_bounce_cnt;

  logic [PosW-1:0] w_h, w_v;
  rgb332_t         w_rgb, r_rgb;

  assign w_frame_tick = bus.vblank & ~r_vblank_q;

  // vblank delay for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_vblank_q <= 1'b0;
    else       r_vblank_q <= bus.vblank;
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // FSM next state: idle until an unpaused frame tick, then walk every ball once.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_proc       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_frame_tick && !bus.pause) begin
          w_start      = 1'b1;
          w_state_next = StUpdate;
        end
      end
      StUpdate: begin
        w_proc = 1'b1;
        if (r_idx == LastIdx) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_x_cur    = r_x[r_idx];
  assign w_y_cur    = r_y[r_idx];
  assign w_hdir_cur = r_hdir[r_idx];
  assign w_vdir_cur = r_vdir[r_idx];

  ball_axis_step u_x_step (
    .i_pos     (w_x_cur),
    .i_dir     (w_hdir_cur),
    .i_spd     (r_spd),
    .i_max     (XMax),
    .o_pos     (w_x_next),
    .o_dir     (w_hdir_next),
    .o_reflect (w_x_refl)
  );

  ball_axis_step u_y_step (
    .i_pos     (w_y_cur),
    .i_dir     (w_vdir_cur),
    .i_spd     (r_spd),
    .i_max     (YMax),
    .o_pos     (w_y_next),
    .o_dir     (w_vdir_next),
    .o_reflect (w_y_refl)
  );

  // Ball state: staggered reset layout, speed latch on tick, one ball per UPDATE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        r_x[i]    <= PosW'(INIT_X + i * STAGGER);
        r_y[i]    <= PosW'(INIT_Y);
        r_hdir[i] <= i[0];
        r_vdir[i] <= i[1];
      end
      r_spd <= '0;
      r_idx <= '0;
    end else if (w_start) begin
      r_spd <= bus.speed;
      r_idx <= '0;
    end else if (w_proc) begin
      r_x[r_idx]    <= w_x_next;
      r_y[r_idx]    <= w_y_next;
      r_hdir[r_idx] <= w_hdir_next;
      r_vdir[r_idx] <= w_vdir_next;
      r_idx         <= r_idx + IdxW'(1);
    end
  end

  // Bounce pulse and counter; a corner hit counts once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bounce     <= 1'b0;
      r_bounce_cnt <= '0;
    end else begin
      r_bounce <= w_proc & (w_x_refl | w_y_refl);
      if (w_proc && (w_x_refl || w_y_refl)) r_bounce_cnt <= r_bounce_cnt + 8'd1;
    end
  end

  assign w_h = {1'b0, bus.hcount};
  assign w_v = {1'b0, bus.vcount};

  // Pixel colour: walk from the highest index down so the lowest hit wins.
  always_comb begin
    w_rgb = rgb332_split(BG_COLOR);
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (w_h >= r_x[i] && w_h < r_x[i] + Size && w_v >= r_y[i] && w_v < r_y[i] + Size) begin
        w_rgb = rgb332_split(BALL_COLORS[8*i +: 8]);
      end
    end
    if (w_h >= PosW'(HPIXELS) || w_v >= PosW'(VPIXELS)) w_rgb = '0;
  end

  // Registered colour output, one clock behind hcount/vcount.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_rgb <= '0;
    else       r_rgb <= w_rgb;
  end

  assign bus.red        = r_rgb.r;
  assign bus.green      = r_rgb.g;
  assign bus.blue       = r_rgb.b;
  assign bus.busy       = (r_state == StUpdate);
  assign bus.bounce     = r_bounce;
  assign bus.bounce_cnt = r_bounce_cnt;

endmodule
